vf_ramp_ctrl: RTL and testbench

//  Run/stop sequencer and V/f set-point scheduler for controlador_PWM in the inverter.

---
 rtl/vf_ramp_ctrl_if.sv | 12 +
 rtl/vf_ramp_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_vf_ramp_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/vf_ramp_ctrl_if.sv
// Speed-command handshake between the command source and the V/f ramp sequencer.
interface vf_ramp_ctrl_if #(
  parameter int FREQ_W = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [FREQ_W-1:0] cmd_freq;
  logic              cmd_run;

  modport master (output cmd_valid, output cmd_freq, output cmd_run, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_freq, input cmd_run, output cmd_ready);
endinterface

// File: rtl/vf_ramp_ctrl.sv
// Run/stop sequencer and V/f set-point scheduler for the PWM reference generator.
// Ramps frequency toward the commanded target, derives amplitude, gates the drivers and latches faults.
module vf_ramp_ctrl #(
  parameter int FREQ_W    = 12,
  parameter int F_MAX     = 600,
  parameter int RAMP_DIV  = 50000,
  parameter int RAMP_STEP = 1,
  parameter int START_CYC = 5000,
  parameter int KVF       = 1747,
  parameter int AMP_MAX   = 4095,
  parameter int AMP_BOOST = 205
) (
  input  logic              clk_50_i,
  input  logic              rst_i,
  vf_ramp_ctrl_if.slave     cmd_if,
  input  logic              fault_in_i,
  input  logic              fault_clr_i,
  output logic [FREQ_W-1:0] freq_out_o,
  output logic [11:0]       amp_out_o,
  output logic              pwm_en_o,
  output logic              upd_strobe_o,
  output logic              at_speed_o,
  output logic [2:0]        state_out_o
);

  localparam int PROD_W  = FREQ_W + 12;
  localparam int TICK_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int START_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(RAMP_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_ONE   = TICK_W'(1);
  localparam logic [TICK_W-1:0]  TICK_ZERO  = {TICK_W{1'b0}};
  localparam logic [START_W-1:0] START_LAST = START_W'(START_CYC - 1);
  localparam logic [START_W-1:0] START_ONE  = START_W'(1);
  localparam logic [START_W-1:0] START_ZERO = {START_W{1'b0}};
  localparam logic [FREQ_W-1:0]  F_MAX_W    = FREQ_W'(F_MAX);
  localparam logic [FREQ_W-1:0]  STEP_W     = FREQ_W'(RAMP_STEP);
  localparam logic [FREQ_W-1:0]  FREQ_ZERO  = {FREQ_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  state_e             state_q;
  logic [FREQ_W-1:0]  target_q;
  logic [FREQ_W-1:0]  freq_q;
  logic [11:0]        amp_q;
  logic               pwm_en_q;
  logic               upd_strobe_q;
  logic               at_speed_q;
  logic [TICK_W-1:0]  tick_q;
  logic [START_W-1:0] start_cnt_q;

  logic [FREQ_W-1:0]  step_freq_s;
  logic [11:0]        step_amp_s;
  logic [FREQ_W-1:0]  cmd_target_s;
  logic               cmd_accept_s;

  function automatic logic [11:0] amp_of(input logic [FREQ_W-1:0] f);
    logic [PROD_W-1:0] scaled;
    scaled = ({{12{1'b0}}, f} * PROD_W'(KVF)) >> 4'd8;
    if (f == FREQ_ZERO) begin
      amp_of = 12'd0;
    end else if (scaled > PROD_W'(AMP_MAX)) begin
      amp_of = 12'(AMP_MAX);
    end else if (scaled < PROD_W'(AMP_BOOST)) begin
      amp_of = 12'(AMP_BOOST);
    end else begin
      amp_of = scaled[11:0];
    end
  endfunction

  assign cmd_if.cmd_ready = (state_q != ST_FAULT) && !fault_in_i;
  assign cmd_accept_s     = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign step_amp_s       = amp_of(step_freq_s);

  // Clamped command target and the next frequency one step toward target, landing exactly on it.
  always_comb begin
    cmd_target_s = FREQ_ZERO;
    step_freq_s  = freq_q;
    if (!cmd_if.cmd_run) begin
      cmd_target_s = FREQ_ZERO;
    end else if (cmd_if.cmd_freq > F_MAX_W) begin
      cmd_target_s = F_MAX_W;
    end else begin
      cmd_target_s = cmd_if.cmd_freq;
    end
    if (target_q > freq_q) begin
      if ((target_q - freq_q) <= STEP_W) step_freq_s = target_q;
      else                               step_freq_s = freq_q + STEP_W;
    end else if (target_q < freq_q) begin
      if ((freq_q - target_q) <= STEP_W) step_freq_s = target_q;
      else                               step_freq_s = freq_q - STEP_W;
    end else begin
      step_freq_s = freq_q;
    end
  end

  // Sequencer; a fault overrides every state and zeroes the set-points on the following edge.
  always_ff @(posedge clk_50_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      target_q     <= FREQ_ZERO;
      freq_q       <= FREQ_ZERO;
      amp_q        <= 12'd0;
      pwm_en_q     <= 1'b0;
      upd_strobe_q <= 1'b0;
      at_speed_q   <= 1'b0;
      tick_q       <= TICK_ZERO;
      start_cnt_q  <= START_ZERO;
    end else if (fault_in_i) begin
      state_q      <= ST_FAULT;
      target_q     <= FREQ_ZERO;
      freq_q       <= FREQ_ZERO;
      amp_q        <= 12'd0;
      pwm_en_q     <= 1'b0;
      at_speed_q   <= 1'b0;
      tick_q       <= TICK_ZERO;
      start_cnt_q  <= START_ZERO;
      upd_strobe_q <= (freq_q != FREQ_ZERO) || (amp_q != 12'd0);
    end else begin
      upd_strobe_q <= 1'b0;
      if (cmd_accept_s) target_q <= cmd_target_s;
      else              target_q <= target_q;
      case (state_q)
        ST_IDLE: begin
          pwm_en_q   <= 1'b0;
          at_speed_q <= 1'b0;
          if (target_q != FREQ_ZERO) begin
            state_q     <= ST_START;
            start_cnt_q <= START_ZERO;
            pwm_en_q    <= 1'b1;
          end
        end
        ST_START: begin
          if (target_q == FREQ_ZERO) begin
            state_q  <= ST_IDLE;
            pwm_en_q <= 1'b0;
          end else if (start_cnt_q == START_LAST) begin
            state_q <= ST_RAMP;
            tick_q  <= TICK_ZERO;
          end else begin
            start_cnt_q <= start_cnt_q + START_ONE;
          end
        end
        ST_RAMP: begin
          if (freq_q == target_q) begin
            if (target_q != FREQ_ZERO) begin
              state_q    <= ST_RUN;
              at_speed_q <= 1'b1;
            end else begin
              state_q  <= ST_IDLE;
              pwm_en_q <= 1'b0;
            end
          end else if (tick_q == TICK_LAST) begin
            freq_q       <= step_freq_s;
            amp_q        <= step_amp_s;
            upd_strobe_q <= 1'b1;
            tick_q       <= TICK_ZERO;
          end else begin
            tick_q <= tick_q + TICK_ONE;
          end
        end
        ST_RUN: begin
          if (target_q != freq_q) begin
            state_q    <= ST_RAMP;
            at_speed_q <= 1'b0;
            tick_q     <= TICK_ZERO;
          end
        end
        ST_FAULT: begin
          pwm_en_q <= 1'b0;
          if (fault_clr_i) state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          target_q   <= FREQ_ZERO;
          freq_q     <= FREQ_ZERO;
          amp_q      <= 12'd0;
          pwm_en_q   <= 1'b0;
          at_speed_q <= 1'b0;
        end
      endcase
    end
  end

  assign freq_out_o   = freq_q;
  assign amp_out_o    = amp_q;
  assign pwm_en_o     = pwm_en_q;
  assign upd_strobe_o = upd_strobe_q;
  assign at_speed_o   = at_speed_q;
  assign state_out_o  = state_q;

endmodule

// File: tb/tb_vf_ramp_ctrl.sv
// Directed bench for vf_ramp_ctrl with a short ramp divider and start delay.
module tb_vf_ramp_ctrl;

  logic        clk_50;
  logic        rst;
  logic        fault_in;
  logic        fault_clr;
  logic [11:0] freq_out;
  logic [11:0] amp_out;
  logic        pwm_en;
  logic        upd_strobe;
  logic        at_speed;
  logic [2:0]  state_out;

  int vectors     = 0;
  int miscompares = 0;
  int strobes     = 0;

  vf_ramp_ctrl_if #(.FREQ_W(12)) cmd_if ();

  vf_ramp_ctrl #(
    .FREQ_W(12), .F_MAX(600), .RAMP_DIV(4), .RAMP_STEP(1), .START_CYC(3),
    .KVF(1747), .AMP_MAX(4095), .AMP_BOOST(205)
  ) dut (
    .clk_50_i     (clk_50),
    .rst_i        (rst),
    .cmd_if       (cmd_if),
    .fault_in_i   (fault_in),
    .fault_clr_i  (fault_clr),
    .freq_out_o   (freq_out),
    .amp_out_o    (amp_out),
    .pwm_en_o     (pwm_en),
    .upd_strobe_o (upd_strobe),
    .at_speed_o   (at_speed),
    .state_out_o  (state_out)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
    if (upd_strobe === 1'b1) strobes++;
  endtask

  task automatic send(input logic [11:0] f, input logic run);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_freq  = f;
    cmd_if.cmd_run   = run;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_freq(input string tag, input logic [11:0] f, input int budget);
    int n;
    n = 0;
    while (freq_out !== f && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(freq_out), 32'(f));
  endtask

  initial begin
    logic [11:0] prev;
    bit          done;

    rst = 1'b1; fault_in = 1'b0; fault_clr = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_freq = 12'd0; cmd_if.cmd_run = 1'b0;

    // 1: reset
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_freq", 32'(freq_out), 32'd0);
    chk("rst_amp", 32'(amp_out), 32'd0);
    chk("rst_pwm", 32'(pwm_en), 32'd0);
    chk("rst_upd", 32'(upd_strobe), 32'd0);
    chk("rst_atspd", 32'(at_speed), 32'd0);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // 2: run at 10 from idle
    strobes = 0;
    send(12'd10, 1'b1);
    chk("s2_accept_idle", 32'(state_out), 32'd0);
    tick();
    chk("s2_start", 32'(state_out), 32'd1);
    chk("s2_start_pwm", 32'(pwm_en), 32'd1);
    tick(); tick();
    chk("s2_start_hold", 32'(state_out), 32'd1);
    tick();
    chk("s2_ramp_entry", 32'(state_out), 32'd2);
    repeat (3) tick();
    chk("s2_no_early_step", 32'(freq_out), 32'd0);
    tick();
    chk("s2_first_freq", 32'(freq_out), 32'd1);
    chk("s2_first_amp", 32'(amp_out), 32'd205);
    chk("s2_first_upd", 32'(upd_strobe), 32'd1);
    for (int k = 2; k <= 10; k++) begin
      repeat (3) tick();
      chk("s2_hold", 32'(freq_out), 32'(k - 1));
      tick();
      chk("s2_step", 32'(freq_out), 32'(k));
    end
    chk("s2_amp10", 32'(amp_out), 32'd205);
    tick();
    chk("s2_run", 32'(state_out), 32'd3);
    chk("s2_atspd", 32'(at_speed), 32'd1);
    chk("s2_strobes", 32'(strobes), 32'd10);

    // 4: stop from run at 10
    strobes = 0;
    send(12'd10, 1'b0);
    chk("s4_still_run", 32'(state_out), 32'd3);
    tick();
    chk("s4_ramp", 32'(state_out), 32'd2);
    chk("s4_atspd_low", 32'(at_speed), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      repeat (3) tick();
      chk("s4_hold", 32'(freq_out), 32'(11 - k));
      tick();
      chk("s4_step", 32'(freq_out), 32'(10 - k));
    end
    chk("s4_amp0", 32'(amp_out), 32'd0);
    chk("s4_pwm_still_on", 32'(pwm_en), 32'd1);
    tick();
    chk("s4_idle", 32'(state_out), 32'd0);
    chk("s4_pwm_off", 32'(pwm_en), 32'd0);
    chk("s4_strobes", 32'(strobes), 32'd10);

    // 6: ramp toward 20, retarget to 3 once at 8
    send(12'd20, 1'b1);
    wait_freq("s6_reach8", 12'd8, 100);
    chk("s6_ramping", 32'(state_out), 32'd2);
    send(12'd3, 1'b1);
    strobes = 0;
    prev = 12'd8;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      chk("s6_window", 32'(freq_out <= 12'd8 && freq_out >= 12'd3 && freq_out <= prev), 32'd1);
      prev = freq_out;
      if (state_out == 3'd3) done = 1'b1;
    end
    chk("s6_run", 32'(state_out), 32'd3);
    chk("s6_freq", 32'(freq_out), 32'd3);
    chk("s6_strobes", 32'(strobes), 32'd5);

    // 5: fault at 5 mid-ramp, command in the same cycle is dropped
    send(12'd10, 1'b1);
    wait_freq("s5_reach5", 12'd5, 60);
    chk("s5_ramping", 32'(state_out), 32'd2);
    fault_in = 1'b1;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_freq = 12'd12; cmd_if.cmd_run = 1'b1;
    #1;
    chk("s5_ready_fault_in", 32'(cmd_if.cmd_ready), 32'd0);
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("s5_fault", 32'(state_out), 32'd4);
    chk("s5_freq0", 32'(freq_out), 32'd0);
    chk("s5_amp0", 32'(amp_out), 32'd0);
    chk("s5_pwm0", 32'(pwm_en), 32'd0);
    chk("s5_upd", 32'(upd_strobe), 32'd1);
    tick();
    chk("s5_upd_once", 32'(upd_strobe), 32'd0);
    fault_clr = 1'b1;
    tick();
    chk("s5_clr_ignored", 32'(state_out), 32'd4);
    fault_in = 1'b0;
    #1;
    chk("s5_ready_in_fault", 32'(cmd_if.cmd_ready), 32'd0);
    tick();
    fault_clr = 1'b0;
    chk("s5_exit_idle", 32'(state_out), 32'd0);
    chk("s5_ready_back", 32'(cmd_if.cmd_ready), 32'd1);
    repeat (3) tick();
    chk("s5_cmd_dropped", 32'(state_out), 32'd0);
    chk("s5_pwm_off", 32'(pwm_en), 32'd0);

    // 3: clamp 900 -> 600, amplitude curve points, then reset mid-run
    send(12'd900, 1'b1);
    wait_freq("s3_reach30", 12'd30, 400);
    chk("s3_amp30_boost", 32'(amp_out), 32'd205);
    wait_freq("s3_reach31", 12'd31, 10);
    chk("s3_amp31", 32'(amp_out), 32'd211);
    wait_freq("s3_reach100", 12'd100, 400);
    chk("s3_amp100", 32'(amp_out), 32'd682);
    done = 1'b0;
    for (int i = 0; i < 2200 && !done; i++) begin
      tick();
      if (state_out == 3'd3) done = 1'b1;
    end
    chk("s3_run", 32'(state_out), 32'd3);
    chk("s3_freq_clamp", 32'(freq_out), 32'd600);
    chk("s3_amp600", 32'(amp_out), 32'd4094);
    chk("s3_atspd", 32'(at_speed), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_state", 32'(state_out), 32'd0);
    chk("mid_rst_freq", 32'(freq_out), 32'd0);
    chk("mid_rst_amp", 32'(amp_out), 32'd0);
    chk("mid_rst_pwm", 32'(pwm_en), 32'd0);
    chk("mid_rst_atspd", 32'(at_speed), 32'd0);
    repeat (3) tick();
    chk("mid_rst_target0", 32'(state_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
